// File: rtl/link_frame_scheduler_if.sv
// rtl/link_frame_scheduler_if.sv - UART TX/RX FIFO port bundle for the link frame scheduler
interface link_frame_scheduler_if;
  logic [7:0] w_data;
  logic       wr_uart;
  logic       tx_full;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;

  modport master (
    output w_data, wr_uart, rd_uart,
    input  tx_full, rx_empty, r_data
  );

  modport slave (
    input  w_data, wr_uart, rd_uart,
    output tx_full, rx_empty, r_data
  );
endinterface

// File: rtl/link_frame_scheduler.sv
// rtl/link_frame_scheduler.sv - periodic 5-byte car-state frame TX and resyncing, checksummed RX
module link_frame_scheduler #(
  parameter int         TICK_CYCLES   = 1_625_000,
  parameter int         TIMEOUT_TICKS = 8,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [23:0]             local_payload,
  link_frame_scheduler_if.master  uart,
  output logic [23:0]             remote_payload,
  output logic                    frame_ok,
  output logic                    chk_err,
  output logic [7:0]              err_cnt,
  output logic                    link_up
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int OW = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;

  typedef enum logic {T_IDLE, T_SEND} tx_state_t;
  typedef enum logic [1:0] {R_HUNT, R_PAY, R_CHK} rx_state_t;

  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TW'(TICK_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

  tx_state_t   tx_state, tx_next;
  logic [2:0]  tx_idx;
  logic [23:0] tx_buf;
  logic        pending;
  logic        tx_start, tx_push;
  logic [7:0]  tx_byte;

  always_comb begin
    tx_next  = tx_state;
    tx_start = 1'b0;
    tx_push  = 1'b0;
    case (tx_state)
      T_IDLE: if ((tick || pending) && en) begin
        tx_start = 1'b1;
        tx_next  = T_SEND;
      end
      // Registered strobe: never push in the cycle wr_uart is already high.
      T_SEND: if (!uart.tx_full && !uart.wr_uart) begin
        tx_push = 1'b1;
        if (tx_idx == 3'd4) tx_next = T_IDLE;
      end
    endcase
  end

  always_comb begin
    case (tx_idx)
      3'd0:    tx_byte = SYNC_BYTE;
      3'd1:    tx_byte = tx_buf[7:0];
      3'd2:    tx_byte = tx_buf[15:8];
      3'd3:    tx_byte = tx_buf[23:16];
      default: tx_byte = tx_buf[7:0] ^ tx_buf[15:8] ^ tx_buf[23:16];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= T_IDLE;
    else     tx_state <= tx_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uart.wr_uart <= 1'b0;
      uart.w_data  <= 8'h00;
      tx_idx       <= 3'd0;
      tx_buf       <= 24'h0;
      pending      <= 1'b0;
    end else begin
      uart.wr_uart <= tx_push;
      if (tx_push) begin
        uart.w_data <= tx_byte;
        tx_idx      <= tx_idx + 3'd1;
      end
      if (tx_start) begin
        tx_buf <= local_payload;
        tx_idx <= 3'd0;
      end
      // One-deep: ticks arriving mid-frame coalesce into a single follow-up frame.
      if (tx_start)                          pending <= 1'b0;
      else if (tick && tx_state == T_SEND)   pending <= 1'b1;
    end
  end

  rx_state_t   rx_state, rx_next;
  logic [1:0]  rx_idx;
  logic [23:0] rx_buf;
  logic        rx_take, rx_good, rx_bad;
  logic [OW-1:0] tmo;

  assign rx_take = !uart.rx_empty && !uart.rd_uart;

  always_comb begin
    rx_next = rx_state;
    rx_good = 1'b0;
    rx_bad  = 1'b0;
    case (rx_state)
      R_HUNT: if (rx_take && uart.r_data == SYNC_BYTE) rx_next = R_PAY;
      R_PAY:  if (rx_take && rx_idx == 2'd2)           rx_next = R_CHK;
      R_CHK:  if (rx_take) begin
        rx_next = R_HUNT;
        if (uart.r_data == (rx_buf[7:0] ^ rx_buf[15:8] ^ rx_buf[23:16])) rx_good = 1'b1;
        else                                                             rx_bad  = 1'b1;
      end
      default: rx_next = R_HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= R_HUNT;
    else     rx_state <= rx_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uart.rd_uart   <= 1'b0;
      rx_idx         <= 2'd0;
      rx_buf         <= 24'h0;
      remote_payload <= 24'h0;
      frame_ok       <= 1'b0;
      chk_err        <= 1'b0;
      err_cnt        <= 8'h00;
      tmo            <= '0;
      link_up        <= 1'b0;
    end else begin
      uart.rd_uart <= rx_take;
      frame_ok     <= rx_good;
      chk_err      <= rx_bad;
      // Payload shifts in from the top so the first byte (speed) lands in [7:0].
      if (rx_state == R_HUNT) begin
        rx_idx <= 2'd0;
      end else if (rx_state == R_PAY && rx_take) begin
        rx_buf <= {uart.r_data, rx_buf[23:8]};
        rx_idx <= rx_idx + 2'd1;
      end
      if (rx_good) remote_payload <= rx_buf;
      if (rx_bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (rx_good) begin
        tmo     <= '0;
        link_up <= 1'b1;
      end else if (tick) begin
        if (tmo != OW'(TIMEOUT_TICKS))      tmo     <= tmo + OW'(1);
        if (tmo >= OW'(TIMEOUT_TICKS - 1))  link_up <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_link_frame_scheduler.sv
// tb/tb_link_frame_scheduler.sv - directed table-driven bench for link_frame_scheduler
module tb_link_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [23:0] local_payload = 24'h0;
  logic [23:0] remote_payload;
  logic        frame_ok, chk_err, link_up;
  logic [7:0]  err_cnt;

  link_frame_scheduler_if ifc();

  link_frame_scheduler #(
    .TICK_CYCLES(16), .TIMEOUT_TICKS(2), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .local_payload(local_payload), .uart(ifc),
    .remote_payload(remote_payload), .frame_ok(frame_ok), .chk_err(chk_err),
    .err_cnt(err_cnt), .link_up(link_up)
  );

  always #5 clk = ~clk;

  logic [7:0] rx_q[$];
  logic [7:0] tx_log[$];
  int  ok_cnt = 0;
  int  err_pulses = 0;
  int  pe_cnt;
  bit  loopback = 1'b0;
  int  total = 0;
  int  passed = 0;

  typedef struct {
    int          n;
    logic [55:0] bytes;
    int          d_ok;
    int          d_err;
    logic [23:0] remote;
    logic [7:0]  ecnt;
  } rx_vec_t;

  rx_vec_t tbl [0:4];

  always @(posedge clk or posedge rst) begin
    if (rst) pe_cnt <= 0;
    else     pe_cnt <= pe_cnt + 1;
  end

  // FIFO models and pulse counters, all sampled on the falling edge.
  always @(negedge clk) begin
    if (ifc.rd_uart && rx_q.size() > 0) void'(rx_q.pop_front());
    if (ifc.wr_uart) begin
      tx_log.push_back(ifc.w_data);
      if (loopback) rx_q.push_back(ifc.w_data);
    end
    if (frame_ok) ok_cnt++;
    if (chk_err)  err_pulses++;
    ifc.rx_empty = (rx_q.size() == 0);
    ifc.r_data   = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic timed_out(input string name);
    total++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_w_data"},  {24'h0, ifc.w_data}, 32'h0);
    check({tag, "_wr_uart"}, {31'h0, ifc.wr_uart}, 32'h0);
    check({tag, "_rd_uart"}, {31'h0, ifc.rd_uart}, 32'h0);
    check({tag, "_remote"},  {8'h0, remote_payload}, 32'h0);
    check({tag, "_frame_ok"}, {31'h0, frame_ok}, 32'h0);
    check({tag, "_chk_err"}, {31'h0, chk_err}, 32'h0);
    check({tag, "_err_cnt"}, {24'h0, err_cnt}, 32'h0);
    check({tag, "_link_up"}, {31'h0, link_up}, 32'h0);
  endtask

  task automatic wait_tx(input int n, input int budget, input string name);
    int c = 0;
    while (tx_log.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (tx_log.size() < n) timed_out(name);
  endtask

  task automatic wait_ok(input int n, input int budget, input string name);
    int c = 0;
    while (ok_cnt < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (ok_cnt < n) timed_out(name);
  endtask

  task automatic drain(input int budget, input string name);
    int c = 0;
    while ((rx_q.size() != 0 || ifc.rd_uart) && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (rx_q.size() != 0) timed_out(name);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_ticks(input int n, input string name);
    int seen = 0;
    for (int c = 0; c < 40 * n && seen < n; c++) begin
      @(negedge clk);
      if (pe_cnt > 0 && pe_cnt % 16 == 0) seen++;
    end
    if (seen < n) timed_out(name);
  endtask

  task automatic push_bytes(input int n, input logic [55:0] b);
    for (int j = 0; j < n; j++) rx_q.push_back(b[55 - 8*j -: 8]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [39:0] exp1;
    logic [79:0] exp4;
    int base_ok, base_err;

    tbl[0] = '{7, 56'h00_13_A5_01_02_03_00, 1, 0, 24'h030201, 8'd0};
    tbl[1] = '{5, 56'hA5_01_02_03_FF_00_00, 0, 1, 24'h030201, 8'd1};
    tbl[2] = '{5, 56'hA5_10_20_30_00_00_00, 1, 0, 24'h302010, 8'd1};
    tbl[3] = '{5, 56'hA5_A5_11_22_96_00_00, 1, 0, 24'h2211A5, 8'd1};
    tbl[4] = '{6, 56'hFF_A5_00_00_00_01_00, 0, 1, 24'h2211A5, 8'd2};
    exp1 = 40'hA5_7F_40_03_3C;
    exp4 = 80'hA5_12_5A_C3_8B_A5_01_FF_00_FE;

    ifc.tx_full = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset0");
    rst = 1'b0;

    // Loopback frame, then link timeout over two ticks
    local_payload = 24'h03407F;
    loopback = 1'b1;
    en = 1'b1;
    wait_tx(1, 40, "t1_first_byte");
    en = 1'b0;
    wait_tx(5, 40, "t1_tx_bytes");
    wait_ok(1, 40, "t1_frame_ok");
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++)
      check($sformatf("t1_tx_byte%0d", i), {24'h0, (tx_log.size() > i) ? tx_log[i] : 8'hxx},
            {24'h0, exp1[39 - 8*i -: 8]});
    check("t1_ok_pulses", ok_cnt, 1);
    check("t1_remote", {8'h0, remote_payload}, 32'h0003407F);
    check("t1_link_up", {31'h0, link_up}, 32'h1);
    loopback = 1'b0;
    wait_ticks(1, "t5_tick1");
    check("t5_link_after_tick1", {31'h0, link_up}, 32'h1);
    wait_ticks(1, "t5_tick2");
    check("t5_link_after_tick2", {31'h0, link_up}, 32'h0);

    // RX vectors: garbage, checksum error, sync-in-payload
    for (int i = 0; i < 5; i++) begin
      base_ok  = ok_cnt;
      base_err = err_pulses;
      push_bytes(tbl[i].n, tbl[i].bytes);
      drain(100, $sformatf("rx%0d_drain", i));
      check($sformatf("rx%0d_ok", i), ok_cnt - base_ok, tbl[i].d_ok);
      check($sformatf("rx%0d_err", i), err_pulses - base_err, tbl[i].d_err);
      check($sformatf("rx%0d_remote", i), {8'h0, remote_payload}, {8'h0, tbl[i].remote});
      check($sformatf("rx%0d_err_cnt", i), {24'h0, err_cnt}, {24'h0, tbl[i].ecnt});
    end

    // tx_full stall on byte 2; ticks during stall yield exactly one extra frame
    tx_log.delete();
    local_payload = 24'hC35A12;
    en = 1'b1;
    wait_tx(2, 40, "t4_two_bytes");
    ifc.tx_full = 1'b1;
    local_payload = 24'h00FF01;
    repeat (100) @(negedge clk);
    check("t4_stall_no_push", tx_log.size(), 2);
    ifc.tx_full = 1'b0;
    wait_tx(6, 80, "t4_extra_start");
    en = 1'b0;
    wait_tx(10, 80, "t4_extra_done");
    repeat (60) @(negedge clk);
    check("t5_exactly_one_extra", tx_log.size(), 10);
    for (int i = 0; i < 10; i++)
      check($sformatf("t4_byte%0d", i), {24'h0, (tx_log.size() > i) ? tx_log[i] : 8'hxx},
            {24'h0, exp4[79 - 8*i -: 8]});

    // Reset mid-RX, then a clean frame
    push_bytes(2, 56'hA5_01_00_00_00_00_00);
    drain(40, "t6_partial_drain");
    rst = 1'b1;
    #1;
    check_reset("reset6");
    @(negedge clk);
    rst = 1'b0;
    base_ok  = ok_cnt;
    base_err = err_pulses;
    push_bytes(5, 56'hA5_04_05_06_07_00_00);
    drain(100, "t6_drain");
    check("t6_ok", ok_cnt - base_ok, 1);
    check("t6_err", err_pulses - base_err, 0);
    check("t6_remote", {8'h0, remote_payload}, 32'h00060504);
    check("t6_err_cnt", {24'h0, err_cnt}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
